button_event_scheduler: RTL
===========================

Name: button_event_scheduler

Overview:
Multi-button front end for the simple processor's user inputs. It owns the slow sampling tick, debounces N_BTN raw push-buttons with a per-button state machine, and turns each debounced press into a one-shot event. Pending events are shared onto a single valid/ready event port by a round-robin arbiter, so the processor's input logic or FSM consumes exactly one event per physical press.

Parameters:
N_BTN, 4, number of buttons (2..8)
CLK_DIV, 500000, clk cycles per sample tick (>=2)
STABLE_TICKS, 3, consecutive ticks a new level must persist before acceptance (1..15)
ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed

Ports:
clk  in  1  system clock; all state is on the rising edge
reset  in  1  asynchronous, active-high reset
pb_raw  in  N_BTN  raw button pins, asynchronous
btn_level  out  N_BTN  debounced level per button, 1 = pressed
evt_valid  out  1  event available
evt_id  out  clog2(N_BTN)  index of the pressed button; stable while evt_valid=1
evt_ready  in  1  consumer accepts; transfer when evt_valid & evt_ready
evt_overrun  out  1  sticky: a press was lost
overrun_clr  in  1  clears evt_overrun

Behaviour:
- Reset is asynchronous and active-high. While reset=1: btn_level=0, evt_valid=0, evt_id=0, evt_overrun=0, all pending bits=0, tick counter=0, every button FSM in RELEASED with count 0, rr pointer=N_BTN-1 (button 0 has first priority). Reset mid-operation discards any pending or presented event immediately, with no transfer.
- Sync: each pb_raw bit passes through a 2-flop synchronizer. The polarity is then normalised so that p[i]=1 means pressed.
- Tick: the counter runs 0..CLK_DIV-1 and wraps. tick=1 for the single cycle in which count==CLK_DIV-1. Buttons are evaluated only on tick cycles.
- Per-button FSM (evaluated on tick):
  - RELEASED: if p=1, go to PRESS_WAIT with cnt=1. If STABLE_TICKS==1, go straight to PRESSED instead (see accept below).
  - PRESS_WAIT: if p=0, return to RELEASED with cnt=0. Otherwise cnt+1. When the tick that brings cnt to STABLE_TICKS occurs, go to PRESSED.
  - PRESSED: mirror of RELEASED with p=0, going to RELEASE_WAIT.
  - RELEASE_WAIT: mirror of PRESS_WAIT, going to RELEASED.
  - btn_level[i]=1 in PRESSED and RELEASE_WAIT.
- Accept: the transition into PRESSED asserts press[i] for 1 cycle. A release generates no event.
- Pending: press[i] sets pend[i]. A grant clears pend[i].
  - press[i] in the same cycle as the grant of i: pend[i] stays set. No overrun.
  - press[i] while pend[i]=1 and i is not granted in that cycle: the press is dropped and evt_overrun is set.
- Output slot (EMPTY/FULL):
  - Slot is loadable when evt_valid=0, or when evt_valid & evt_ready.
  - When loadable and any pend bit is set, grant the first set bit searching rr+1, rr+2, ... (mod N_BTN). Then evt_id<=grant, evt_valid<=1, rr<=grant.
  - When loadable and nothing is pending, evt_valid<=0.
  - Latency is 1 clk from pend set to evt_valid if the slot is empty.
  - Back-to-back transfers are sustainable at 1 event per clk while ready=1.
- evt_overrun: set has priority over overrun_clr in the same cycle. Otherwise overrun_clr clears it.
- Press latency: pb_raw edge to press[i] is 2 sync clk plus STABLE_TICKS ticks, with up to 1 tick of phase error.

Test Plan:
Bench parameters: N_BTN=4, CLK_DIV=4, STABLE_TICKS=3, ACTIVE_LOW=1, evt_ready=1 unless stated.
1. Clean press: drive pb_raw[1] low and hold it -> btn_level[1] rises 10..14 clk later. evt_valid is high for exactly 1 clk with evt_id=1. Releasing later produces btn_level[1]=0 and no event.
2. Bounce: drive pb_raw[2] low for 2 ticks, high for 1 tick, repeat 3 times, then high -> btn_level stays 0, no event, overrun=0.
3. Simultaneous press of buttons 0, 2, 3 with evt_ready=0 -> evt_valid=1 with evt_id=0, held stable. Then pulse ready once per 5 clk -> ids 0, 2, 3 in that order, and evt_valid falls after the third transfer.
4. Round robin: after a grant of 3, with pend={0,3} -> next id=0, then 3.
5. Overrun: with ready=0, press 0 (fills the slot), then press, release and press 2 -> evt_overrun=1. Releasing ready yields ids 0 and 2 once each. Pulsing overrun_clr -> evt_overrun=0.
6. Reset mid-operation: assert reset while evt_valid=1 and btn_level=4'b0101 -> evt_valid=0, btn_level=0, overrun=0 in the same cycle. After release with buttons still held, each held button re-debounces and emits a fresh event, starting with id 0.

Source files
------------

// File: rtl/button_event_scheduler.sv
// button_event_scheduler: debounces N_BTN raw buttons on a slow tick and serves one event per press
// over a round-robin arbitrated valid/ready port with a sticky overrun flag.
module button_event_scheduler #(
  parameter int N_BTN        = 4,
  parameter int CLK_DIV      = 500000,
  parameter int STABLE_TICKS = 3,
  parameter bit ACTIVE_LOW   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_BTN-1:0]         pb_raw,
  output logic [N_BTN-1:0]         btn_level,
  output logic                     evt_valid,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  input  logic                     evt_ready,
  output logic                     evt_overrun,
  input  logic                     overrun_clr
);
  localparam int IW = $clog2(N_BTN);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [N_BTN-1:0] IDLE = {N_BTN{ACTIVE_LOW}};
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} st_t;
  logic [N_BTN-1:0] r_s1, r_s2, r_pend, w_p, w_press, w_gnt, w_pend_n;
  logic [CW-1:0] r_tick_cnt;
  logic w_tick, w_load, w_found;
  logic [IW-1:0] r_rr, w_gid, w_j;
  st_t r_st [N_BTN];
  st_t w_st_n [N_BTN];
  logic [3:0] r_c [N_BTN];
  logic [3:0] w_c_n [N_BTN];
  // Synchronizers reset to the idle level so no phantom press appears after reset.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_s1 <= IDLE;
      r_s2 <= IDLE;
      r_tick_cnt <= '0;
    end else begin
      r_s1 <= pb_raw;
      r_s2 <= r_s1;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CW'(1);
    end
  assign w_tick = r_tick_cnt == CW'(CLK_DIV - 1);
  assign w_p = ACTIVE_LOW ? ~r_s2 : r_s2;
  always_comb
    for (int i = 0; i < N_BTN; i++) begin
      w_st_n[i] = r_st[i];
      w_c_n[i] = r_c[i];
      if (w_tick)
        case (r_st[i])
          RELEASED:
            if (w_p[i] && STABLE_TICKS == 1) w_st_n[i] = PRESSED;
            else if (w_p[i]) begin w_st_n[i] = PRESS_WAIT; w_c_n[i] = 4'd1; end
          PRESS_WAIT:
            if (!w_p[i]) begin w_st_n[i] = RELEASED; w_c_n[i] = '0; end
            else if (r_c[i] + 4'd1 == 4'(STABLE_TICKS)) begin w_st_n[i] = PRESSED; w_c_n[i] = '0; end
            else w_c_n[i] = r_c[i] + 4'd1;
          PRESSED:
            if (!w_p[i] && STABLE_TICKS == 1) w_st_n[i] = RELEASED;
            else if (!w_p[i]) begin w_st_n[i] = RELEASE_WAIT; w_c_n[i] = 4'd1; end
          RELEASE_WAIT:
            if (w_p[i]) begin w_st_n[i] = PRESSED; w_c_n[i] = '0; end
            else if (r_c[i] + 4'd1 == 4'(STABLE_TICKS)) begin w_st_n[i] = RELEASED; w_c_n[i] = '0; end
            else w_c_n[i] = r_c[i] + 4'd1;
        endcase
      // A bounce back from RELEASE_WAIT is the same physical press, so only the released side fires.
      w_press[i] = w_st_n[i] == PRESSED && !r_st[i][1];
      btn_level[i] = r_st[i][1];
    end
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < N_BTN; i++) begin
        r_st[i] <= RELEASED;
        r_c[i] <= '0;
      end
    else
      for (int i = 0; i < N_BTN; i++) begin
        r_st[i] <= w_st_n[i];
        r_c[i] <= w_c_n[i];
      end
  always_comb begin
    w_load = !evt_valid || evt_ready;
    w_found = 1'b0;
    w_gid = r_rr;
    w_j = '0;
    w_gnt = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      w_j = IW'((int'(r_rr) + k) % N_BTN);
      if (!w_found && r_pend[w_j]) begin
        w_found = 1'b1;
        w_gid = w_j;
      end
    end
    if (w_load && w_found) w_gnt[w_gid] = 1'b1;
    w_pend_n = (r_pend & ~w_gnt) | w_press;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_pend <= '0;
      evt_valid <= 1'b0;
      evt_id <= '0;
      evt_overrun <= 1'b0;
      r_rr <= IW'(N_BTN - 1);
    end else begin
      r_pend <= w_pend_n;
      if (w_load) evt_valid <= w_found;
      if (w_load && w_found) begin
        evt_id <= w_gid;
        r_rr <= w_gid;
      end
      evt_overrun <= |(w_press & r_pend & ~w_gnt) || (evt_overrun && !overrun_clr);
    end
endmodule
